// File: rtl/elink_pkg.sv
// Shared elink definitions: emesh packet field offsets, burst stride and
// counter widths used across the RX path.
package elink_pkg;

  localparam int WRITE_BIT    = 0;
  localparam int CTRL_LSB     = 4;
  localparam int DST_LSB      = 8;
  localparam int BURST_STRIDE = 8;
  localparam int DROP_W       = 16;

endpackage

// File: rtl/erx_chfifo.sv
// Single-clock first-word-fall-through channel buffer. almost_full looks
// ahead: it reflects the occupancy that will hold after the current edge.
module erx_chfifo #(
  parameter int PW    = 104,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [PW-1:0]          din,
  input  logic                   pop,
  output logic [PW-1:0]          dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   almost_full
);
  localparam int PTRW = $clog2(DEPTH);

  logic [PW-1:0]   mem [DEPTH];
  logic [PTRW-1:0] wr_ptr, rd_ptr;
  logic [PTRW:0]   count_next;
  logic            do_push, do_pop;

  // A pop frees the head slot first, so a full buffer still takes a push.
  assign do_pop  = pop & (count != '0);
  assign do_push = push & (~full | do_pop);
  assign full    = count == (PTRW+1)'(DEPTH);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    count_next = count;
    if (do_push && !do_pop)
      count_next = count + 1'b1;
    else if (!do_push && do_pop)
      count_next = count - 1'b1;
  end

  assign almost_full = count_next >= (PTRW+1)'(DEPTH - 1);

  // NOTE: sequential state uses non-blocking (<=) so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
    end
  end

  // NOTE: storage is not reset; count gates validity, so contents are don't-care.
  always_ff @(posedge clk) begin
    if (do_push && !reset) mem[wr_ptr] <= din;
  end

  assign dout = mem[rd_ptr];

endmodule

// File: rtl/erx_dispatch.sv
// RX packet dispatcher: regenerates burst addresses and routes each emesh
// packet into one of NCH per-channel FWFT buffers, with drop/overflow accounting.
module erx_dispatch
  import elink_pkg::*;
#(
  parameter int PW    = 104,
  parameter int AW    = 32,
  parameter int NCH   = 3,
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_access,
  input  logic              in_burst,
  input  logic [PW-1:0]     in_packet,
  output logic              in_wait,
  output logic [NCH-1:0]    out_access,
  output logic [NCH*PW-1:0] out_packet,
  input  logic [NCH-1:0]    out_wait,
  output logic [DROP_W-1:0] drop_count,
  output logic [NCH-1:0]    overflow
);
  localparam int CSW = $clog2(NCH);
  localparam int CW  = $clog2(DEPTH) + 1;
  localparam logic [CSW:0] NCH_LIM = (CSW+1)'(NCH);

  logic [CSW-1:0] sel_raw, sel, last_sel;
  logic [AW-1:0]  last_addr, burst_addr, route_addr;
  logic           sel_oob, routed;
  logic [PW-1:0]  route_pkt;
  logic [NCH-1:0] push, pop, full, afull;
  logic [CW-1:0]  count [NCH];

  // Burst beats follow the previous routed packet; their own dstaddr is ignored.
  assign sel_raw    = in_packet[CTRL_LSB +: CSW];
  assign sel_oob    = {1'b0, sel_raw} >= NCH_LIM;
  assign burst_addr = last_addr + AW'(BURST_STRIDE);
  assign sel        = in_burst ? last_sel : sel_raw;
  assign route_addr = in_burst ? burst_addr : in_packet[DST_LSB +: AW];
  assign routed     = in_access & (in_burst | ~sel_oob);

  always_comb begin
    route_pkt                = in_packet;
    route_pkt[DST_LSB +: AW] = route_addr;
  end

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    assign push[c]       = routed & (sel == CSW'(c));
    assign out_access[c] = count[c] != '0;
    assign pop[c]        = out_access[c] & ~out_wait[c];

    erx_chfifo #(
      .PW    (PW),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk         (clk),
      .reset       (reset),
      .push        (push[c]),
      .din         (route_pkt),
      .pop         (pop[c]),
      .dout        (out_packet[c*PW +: PW]),
      .count       (count[c]),
      .full        (full[c]),
      .almost_full (afull[c])
    );
  end

  // in_wait is registered from next-cycle occupancy, leaving one slot for a late sender.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_addr  <= '0;
      last_sel   <= '0;
      drop_count <= '0;
      overflow   <= '0;
      in_wait    <= 1'b0;
    end else begin
      if (routed) begin
        last_addr <= route_addr;
        last_sel  <= sel;
      end
      if (in_access && !in_burst && sel_oob && !(&drop_count))
        drop_count <= drop_count + 1'b1;
      overflow <= overflow | (push & full & ~pop);
      in_wait  <= |afull;
    end
  end

endmodule

// File: tb/tb_erx_dispatch.sv
// Self-checking bench for erx_dispatch: directed scenarios plus a randomized
// stream, compared against a queue-based packet model.
module tb_erx_dispatch;
  localparam int PW    = 104;
  localparam int AW    = 32;
  localparam int NCH   = 3;
  localparam int DEPTH = 4;

  typedef logic [PW-1:0] pkt_t;

  logic             clk;
  logic             reset;
  logic             in_access;
  logic             in_burst;
  pkt_t             in_packet;
  logic             in_wait;
  logic [NCH-1:0]   out_access;
  logic [NCH*PW-1:0] out_packet;
  logic [NCH-1:0]   out_wait;
  logic [15:0]      drop_count;
  logic [NCH-1:0]   overflow;

  erx_dispatch #(.PW(PW), .AW(AW), .NCH(NCH), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_access  (in_access),
    .in_burst   (in_burst),
    .in_packet  (in_packet),
    .in_wait    (in_wait),
    .out_access (out_access),
    .out_packet (out_packet),
    .out_wait   (out_wait),
    .drop_count (drop_count),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: one queue of expected packets per channel.
  pkt_t           mq [NCH][$];
  logic [31:0]    m_last_addr;
  int             m_last_sel;
  int             m_drops;
  logic [NCH-1:0] m_ovf;
  logic           m_wait;

  task automatic check(input string tag, input pkt_t obs, input pkt_t exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic pkt_t mk_pkt(input logic [3:0] ctrl, input logic [31:0] addr);
    logic [127:0] r;
    r        = {$urandom, $urandom, $urandom, $urandom};
    r[7:4]   = ctrl;
    r[39:8]  = addr;
    return r[PW-1:0];
  endfunction

  function automatic logic [31:0] head_addr(input int c);
    return out_packet[c*PW+8 +: 32];
  endfunction

  task automatic model_edge(input logic rst, input logic acc, input logic bst,
                            input pkt_t pkt, input logic [NCH-1:0] ow);
    pkt_t p;
    int   sel;
    if (rst) begin
      for (int c = 0; c < NCH; c++) mq[c].delete();
      m_last_addr = '0;
      m_last_sel  = 0;
      m_drops     = 0;
      m_ovf       = '0;
      m_wait      = 1'b0;
      return;
    end
    for (int c = 0; c < NCH; c++)
      if (mq[c].size() != 0 && !ow[c]) void'(mq[c].pop_front());
    if (acc) begin
      p = pkt;
      if (bst) begin
        sel     = m_last_sel;
        p[39:8] = m_last_addr + 32'd8;
      end else begin
        sel = int'(pkt[7:4]) % 4;
      end
      if (sel >= NCH) begin
        if (m_drops < 65535) m_drops++;
      end else begin
        m_last_sel  = sel;
        m_last_addr = p[39:8];
        if (mq[sel].size() < DEPTH) mq[sel].push_back(p);
        else m_ovf[sel] = 1'b1;
      end
    end
    m_wait = 1'b0;
    for (int c = 0; c < NCH; c++)
      if (mq[c].size() >= DEPTH - 1) m_wait = 1'b1;
  endtask

  task automatic compare_all();
    logic [NCH-1:0] exp_acc;
    check("in_wait", in_wait, m_wait);
    check("drop_count", drop_count, m_drops[15:0]);
    check("overflow", overflow, m_ovf);
    for (int c = 0; c < NCH; c++) exp_acc[c] = mq[c].size() != 0;
    check("out_access", out_access, exp_acc);
    for (int c = 0; c < NCH; c++)
      if (mq[c].size() != 0)
        check($sformatf("head%0d", c), out_packet[c*PW +: PW], mq[c][0]);
  endtask

  task automatic step(input logic rst, input logic acc, input logic bst,
                      input pkt_t pkt, input logic [NCH-1:0] ow);
    reset     = rst;
    in_access = acc;
    in_burst  = bst;
    in_packet = pkt;
    out_wait  = ow;
    @(posedge clk);
    model_edge(rst, acc, bst, pkt, ow);
    #1;
    compare_all();
  endtask

  task automatic idle(input logic [NCH-1:0] ow);
    step(1'b0, 1'b0, 1'b0, '0, ow);
  endtask

  pkt_t sent [5];
  logic seen_wait;

  initial begin
    reset = 1'b1; in_access = 1'b0; in_burst = 1'b0; in_packet = '0; out_wait = '0;
    model_edge(1'b1, 1'b0, 1'b0, '0, '0);

    // Reset state
    step(1'b1, 1'b0, 1'b0, '0, '0);
    step(1'b1, 1'b1, 1'b0, mk_pkt(4'd0, 32'h1234), '0);
    check("rst_out_access", out_access, '0);
    check("rst_in_wait", in_wait, 1'b0);
    check("rst_drop", drop_count, 16'd0);

    // Routing: ctrlmode 0,1,2 on consecutive cycles
    step(1'b0, 1'b1, 1'b0, mk_pkt(4'd0, 32'h100), '0);
    check("route0", out_access, 3'b001);
    step(1'b0, 1'b1, 1'b0, mk_pkt(4'd1, 32'h200), '0);
    check("route1", out_access, 3'b010);
    step(1'b0, 1'b1, 1'b0, mk_pkt(4'd2, 32'h300), '0);
    check("route2", out_access, 3'b100);
    idle('0);
    check("route_done", out_access, 3'b000);

    // Burst address regeneration on ch1, held so all beats accumulate
    step(1'b0, 1'b1, 1'b0, mk_pkt(4'd1, 32'h8000_0000), 3'b010);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, mk_pkt(4'd2, 32'hDEAD_BEEF), 3'b010);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("burst_addr%0d", i), head_addr(1), 32'h8000_0000 + 32'(i * 8));
      idle(3'b000);
    end
    step(1'b0, 1'b1, 1'b0, mk_pkt(4'd1, 32'hFFFF_FFF8), 3'b010);
    step(1'b0, 1'b1, 1'b1, mk_pkt(4'd0, 32'h5555_5555), 3'b010);
    idle(3'b000);
    check("burst_wrap", head_addr(1), 32'h0000_0000);
    idle(3'b000);

    // Drop accounting and saturation
    step(1'b1, 1'b0, 1'b0, '0, '0);
    step(1'b0, 1'b1, 1'b0, mk_pkt(4'd3, 32'h40), '0);
    check("drop_one_count", drop_count, 16'd1);
    check("drop_one_access", out_access, 3'b000);
    for (int i = 0; i < 65536; i++) step(1'b0, 1'b1, 1'b0, mk_pkt(4'd3, 32'h40), '0);
    check("drop_sat", drop_count, 16'hFFFF);

    // Pushback and overflow on a stalled ch0
    step(1'b1, 1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 5; i++) begin
      sent[i] = mk_pkt(4'd0, 32'h1000 + 32'(i));
      step(1'b0, 1'b1, 1'b0, sent[i], 3'b001);
      if (i == 1) check("wait_low_2", in_wait, 1'b0);
      if (i == 2) check("wait_high_3", in_wait, 1'b1);
      if (i == 3) check("no_ovf_4", overflow, 3'b000);
    end
    check("ovf_5", overflow, 3'b001);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("drain%0d", i), out_packet[0 +: PW], sent[i]);
      idle(3'b000);
    end
    check("drained", out_access, 3'b000);

    // Full ch2 with simultaneous push and pop
    step(1'b1, 1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, mk_pkt(4'd2, 32'h2000 + 32'(i)), 3'b100);
    step(1'b0, 1'b1, 1'b0, mk_pkt(4'd2, 32'h2004), 3'b000);
    check("pp_no_ovf", overflow, 3'b000);
    check("pp_head", head_addr(2), 32'h2001);
    for (int i = 0; i < 4; i++) idle(3'b000);
    check("pp_empty", out_access, 3'b000);

    // Randomized stream; sender honours in_wait one cycle late
    seen_wait = 1'b0;
    for (int i = 0; i < 400; i++) begin
      logic acc;
      acc = ($urandom_range(0, 3) != 0) && !seen_wait;
      seen_wait = in_wait;
      step(1'b0, acc, ($urandom_range(0, 2) == 0), mk_pkt(4'($urandom_range(0, 15)), $urandom),
           3'($urandom_range(0, 7)));
    end
    check("rand_no_ovf", overflow, 3'b000);

    // Reset mid-operation with ch0 and ch1 partly full
    step(1'b0, 1'b1, 1'b0, mk_pkt(4'd0, 32'h3000), 3'b011);
    step(1'b0, 1'b1, 1'b1, mk_pkt(4'd0, 32'h0), 3'b011);
    step(1'b0, 1'b1, 1'b0, mk_pkt(4'd1, 32'h3100), 3'b011);
    step(1'b1, 1'b1, 1'b0, mk_pkt(4'd1, 32'h3200), 3'b011);
    check("midrst_access", out_access, 3'b000);
    check("midrst_wait", in_wait, 1'b0);
    check("midrst_ovf", overflow, 3'b000);
    step(1'b0, 1'b1, 1'b1, mk_pkt(4'd2, 32'h7777_0000), 3'b001);
    check("first_burst_ch", out_access, 3'b001);
    check("first_burst_addr", head_addr(0), 32'h0000_0008);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
